// File: rtl/risky_pkg.sv
// -----------------------------------------------------------------------------
// risky_pkg
// Shared constants and types for the register-hazard scoreboard.
//   REG_IDX_W : width of an architectural register index
//   NUM_REGS  : number of architectural registers (x0..x31)
//   REG_ZERO  : index of the hard-wired zero register
//   reg_idx_t : architectural register index type
// -----------------------------------------------------------------------------
package risky_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/scoreboard_counter.sv
// -----------------------------------------------------------------------------
// scoreboard_counter
// In-flight write counter for one architectural register.
//   clk       : clock, state updates on the rising edge
//   rst       : synchronous active-high reset, clears the count
//   inc       : one more write to this register has issued
//   dec       : one write to this register has reached the register file
//   busy      : count != 0 (register has a pending write)
//   full      : count == 2^CNT_W - 1 (no room for another outstanding write)
//   underflow : dec requested while the count is already 0 (combinational)
// An inc and a dec in the same cycle cancel and leave the count unchanged.
// The count saturates at both ends; the owner is expected to never issue into
// a full counter, so the upper clamp is only a safety net.
// -----------------------------------------------------------------------------
module scoreboard_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic full,
    output logic underflow
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    // Next-count selection: saturating up/down, simultaneous inc+dec cancels.
    always_comb begin
        count_nxt_s = count_r;
        case ({inc, dec})
            2'b10: begin
                if (count_r != CNT_MAX) begin
                    count_nxt_s = count_r + CNT_ONE;
                end else begin
                    count_nxt_s = count_r;
                end
            end
            2'b01: begin
                if (count_r != CNT_ZERO) begin
                    count_nxt_s = count_r - CNT_ONE;
                end else begin
                    count_nxt_s = count_r;
                end
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign busy      = (count_r != CNT_ZERO);
    assign full      = (count_r == CNT_MAX);
    assign underflow = dec && (count_r == CNT_ZERO);

endmodule

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
// Register-hazard scoreboard and issue controller between decode and execute.
// Holds a decoded instruction while any of its source registers has a write
// in flight, or while its destination already has the maximum number of
// outstanding writes, and releases it as soon as neither is true.
//   i_clk, i_rst       : clock and synchronous active-high reset
//   i_valid            : decode presents an instruction
//   i_rs1/i_rs1_used   : source 1 index and whether it is read
//   i_rs2/i_rs2_used   : source 2 index and whether it is read
//   i_rd/i_rd_write    : destination index and whether it is written
//   i_wb_valid/i_wb_rd : register file write port (retires one write)
//   o_issue            : instruction leaves decode this cycle (combinational)
//   o_stall            : i_valid && !o_issue
//   o_underflow        : sticky, writeback seen to a register with no writes
//                        in flight
//   o_stall_count      : number of stalled cycles, wraps at 2^32
// x0 never has a counter: it is never pending and writes to it are ignored.
// Writebacks do not bypass into the hazard check; a dependent instruction
// issues the cycle after its producer's writeback.
// -----------------------------------------------------------------------------
module issue_scoreboard
    import risky_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  reg_idx_t    i_rs1,
    input  reg_idx_t    i_rs2,
    input  logic        i_rs1_used,
    input  logic        i_rs2_used,
    input  reg_idx_t    i_rd,
    input  logic        i_rd_write,
    input  logic        i_wb_valid,
    input  reg_idx_t    i_wb_rd,
    output logic        o_issue,
    output logic        o_stall,
    output logic        o_underflow,
    output logic [31:0] o_stall_count
);

    // Bit 0 of busy/full stands for x0 and is tied low so the index decoders
    // can use the register number directly.
    logic [NUM_REGS-1:0] busy_s;
    logic [NUM_REGS-1:0] full_s;
    logic [NUM_REGS-1:1] uflow_s;
    logic [NUM_REGS-1:1] inc_s;
    logic [NUM_REGS-1:1] dec_s;

    logic        raw_s;
    logic        cap_s;
    logic        hazard_s;
    logic        issue_s;
    logic        underflow_r;
    logic [31:0] stall_count_r;

    assign busy_s[0] = 1'b0;
    assign full_s[0] = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_cnt
            scoreboard_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk       (i_clk),
                .rst       (i_rst),
                .inc       (inc_s[g]),
                .dec       (dec_s[g]),
                .busy      (busy_s[g]),
                .full      (full_s[g]),
                .underflow (uflow_s[g])
            );
        end
    endgenerate

    // Hazard detection from registered counter state only (no writeback bypass).
    always_comb begin
        raw_s    = (i_rs1_used && (i_rs1 != REG_ZERO) && busy_s[i_rs1])
                || (i_rs2_used && (i_rs2 != REG_ZERO) && busy_s[i_rs2]);
        cap_s    = i_rd_write && (i_rd != REG_ZERO) && full_s[i_rd];
        hazard_s = raw_s || cap_s;
        issue_s  = i_valid && !hazard_s;
    end

    // One-hot increment/decrement decoders; x0 has no counter to drive.
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_s[r] = issue_s && i_rd_write && (i_rd == reg_idx_t'(r));
            dec_s[r] = i_wb_valid && (i_wb_rd == reg_idx_t'(r));
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            underflow_r <= 1'b0;
        end else if (|uflow_s) begin
            underflow_r <= 1'b1;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    // Stalled-cycle counter, free-running modulo 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_count_r <= 32'd0;
        end else if (i_valid && hazard_s) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign o_issue       = issue_s;
    assign o_stall       = i_valid && hazard_s;
    assign o_underflow   = underflow_r;
    assign o_stall_count = stall_count_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
// Directed scenarios followed by randomized decode/writeback traffic, all
// checked against a per-register pending-write table kept in the bench.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;
    import risky_pkg::*;

    localparam int MAXC = 3;   // 2^CNT_W - 1 with the default CNT_W = 2

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    reg_idx_t    i_rs1 = 5'd0;
    reg_idx_t    i_rs2 = 5'd0;
    logic        i_rs1_used = 1'b0;
    logic        i_rs2_used = 1'b0;
    reg_idx_t    i_rd = 5'd0;
    logic        i_rd_write = 1'b0;
    logic        i_wb_valid = 1'b0;
    reg_idx_t    i_wb_rd = 5'd0;
    logic        o_issue;
    logic        o_stall;
    logic        o_underflow;
    logic [31:0] o_stall_count;

    issue_scoreboard dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .i_rs1_used    (i_rs1_used),
        .i_rs2_used    (i_rs2_used),
        .i_rd          (i_rd),
        .i_rd_write    (i_rd_write),
        .i_wb_valid    (i_wb_valid),
        .i_wb_rd       (i_wb_rd),
        .o_issue       (o_issue),
        .o_stall       (o_stall),
        .o_underflow   (o_underflow),
        .o_stall_count (o_stall_count)
    );

    always #5 i_clk = ~i_clk;

    // Reference state: number of writes in flight per register.
    int          model_cnt [NUM_REGS];
    logic        model_uflow;
    logic [31:0] model_stalls;
    logic        last_issue;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NUM_REGS; r++) model_cnt[r] = 0;
        model_uflow  = 1'b0;
        model_stalls = 32'd0;
    endtask

    // One cycle of stimulus. exp_i >= 0 additionally pins o_issue to a
    // hand-derived value for the directed scenarios.
    task automatic step(input logic v, input reg_idx_t rs1, input logic u1,
                        input reg_idx_t rs2, input logic u2,
                        input reg_idx_t rd, input logic w,
                        input logic wv, input reg_idx_t wr, input int exp_i);
        logic hz;
        logic iss;
        logic same;
        @(negedge i_clk);
        i_valid = v; i_rs1 = rs1; i_rs1_used = u1; i_rs2 = rs2; i_rs2_used = u2;
        i_rd = rd; i_rd_write = w; i_wb_valid = wv; i_wb_rd = wr;
        #1;
        hz  = (u1 && rs1 != 5'd0 && model_cnt[rs1] != 0)
           || (u2 && rs2 != 5'd0 && model_cnt[rs2] != 0)
           || (w && rd != 5'd0 && model_cnt[rd] == MAXC);
        iss = v && !hz;
        check_val("issue", {31'd0, o_issue}, {31'd0, iss});
        check_val("stall", {31'd0, o_stall}, {31'd0, v && !iss});
        if (exp_i >= 0) check_val("dir_issue", {31'd0, o_issue}, 32'(exp_i));
        last_issue = iss;
        @(posedge i_clk);
        #1;
        same = iss && w && rd != 5'd0 && wv && wr == rd;
        if (wv && wr != 5'd0 && model_cnt[wr] == 0) model_uflow = 1'b1;
        if (!same) begin
            if (wv && wr != 5'd0 && model_cnt[wr] != 0) model_cnt[wr]--;
            if (iss && w && rd != 5'd0) model_cnt[rd]++;
        end
        if (v && !iss) model_stalls = model_stalls + 32'd1;
        check_val("underflow", {31'd0, o_underflow}, {31'd0, model_uflow});
        check_val("stall_count", o_stall_count, model_stalls);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_clear();
        check_val("rst_underflow", {31'd0, o_underflow}, 32'd0);
        check_val("rst_stall_count", o_stall_count, 32'd0);
    endtask

    logic     hold;
    logic     v_r, u1_r, u2_r, w_r, wv_r;
    reg_idx_t rs1_r, rs2_r, rd_r, wr_r;

    initial begin
        model_clear();
        last_issue = 1'b0;
        do_reset();

        // Basic RAW stall: producer rd=5, reader rs1=5 waits for writeback.
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1);
        for (int k = 0; k < 3; k++)
            step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 5'd0, 0);
        step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b1, 5'd5, 0);
        step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 5'd0, 1);
        check_val("raw_stall_count", o_stall_count, 32'd4);

        // x0 is never pending; unused operands are ignored.
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1);
        step(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0, 5'd0, 1);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1);
        step(1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1);
        step(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 0);

        // Capacity: three writes to x7 fill the counter, a fourth waits.
        for (int k = 0; k < 3; k++)
            step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 0);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 0);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 0);
        for (int k = 0; k < 3; k++)
            step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, -1);
        step(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1);
        check_val("cap_no_underflow", {31'd0, o_underflow}, 32'd0);

        // Issue and writeback to x3 in the same cycle leave one write pending.
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 1);
        step(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 0);
        step(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 0);
        step(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1);

        // Underflow is sticky until reset and leaves the counter at zero.
        do_reset();
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, -1);
        check_val("uflow_set", {31'd0, o_underflow}, 32'd1);
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, -1);
        check_val("uflow_sticky", {31'd0, o_underflow}, 32'd1);
        step(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1);
        do_reset();

        // Reset during a stall drops the pending write.
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0, 1);
        step(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 0);
        do_reset();
        step(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1);
        check_val("rst_mid_stall_count", o_stall_count, 32'd0);

        // Randomized traffic on a small register window to provoke hazards.
        hold = 1'b0;
        v_r = 1'b0; u1_r = 1'b0; u2_r = 1'b0; w_r = 1'b0;
        rs1_r = 5'd0; rs2_r = 5'd0; rd_r = 5'd0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 750 == 749) begin
                do_reset();
                hold = 1'b0;
            end
            if (!hold) begin
                v_r   = ($urandom_range(9, 0) != 0);
                rs1_r = 5'($urandom_range(7, 0));
                rs2_r = 5'($urandom_range(7, 0));
                rd_r  = 5'($urandom_range(7, 0));
                u1_r  = 1'($urandom_range(1, 0));
                u2_r  = 1'($urandom_range(1, 0));
                w_r   = 1'($urandom_range(1, 0));
            end else if ($urandom_range(9, 0) == 0) begin
                v_r = 1'b0;
            end
            wr_r = 5'($urandom_range(7, 0));
            if (model_cnt[wr_r] != 0) wv_r = ($urandom_range(1, 0) == 1);
            else                      wv_r = ($urandom_range(49, 0) == 0);
            step(v_r, rs1_r, u1_r, rs2_r, u2_r, rd_r, w_r, wv_r, wr_r, -1);
            hold = v_r && !last_issue;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-hazard scoreboard and issue controller placed between the decode stage and execute. Tracks outstanding writes to each architectural register with a per-register in-flight counter. Holds a decoded instruction until its source operands are no longer pending, then grants issue. Retires counters as writeback results reach the register file write port.

## Interface
- `CNT_W`, default 2: width of each per-register in-flight counter. The maximum number of outstanding writes to one register is 2^CNT_W − 1.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst` in 1: reset; synchronous and active-high.
- `i_valid` in 1: decode presents an instruction this cycle.
- `i_rs1` in 5: source register 1 index.
- `i_rs2` in 5: source register 2 index.
- `i_rs1_used` in 1: instruction reads rs1 (R/I/S/B formats).
- `i_rs2_used` in 1: instruction reads rs2 (R/S/B formats).
- `i_rd` in 5: destination register index.
- `i_rd_write` in 1: instruction writes rd (R/I/U/J formats).
- `i_wb_valid` in 1: a result is written to the register file this cycle.
- `i_wb_rd` in 5: writeback destination index.
- `o_issue` out 1: instruction is accepted and leaves decode this cycle.
- `o_stall` out 1: `i_valid && !o_issue`; decode must hold its instruction.
- `o_underflow` out 1: sticky error flag; set by a writeback to a register whose counter is 0.
- `o_stall_count` out 32: number of cycles in which `o_stall` was 1; wraps modulo 2^32.

## Operation
- **State:** 31 counters `cnt[1..31]`, each CNT_W bits. Register x0 has no counter: it is never pending and writes to it are never tracked.
- **Hazard, RAW:** `i_rs1_used && i_rs1!=0 && cnt[i_rs1]!=0`, or the same condition for rs2.
- **Hazard, capacity:** `i_rd_write && i_rd!=0 && cnt[i_rd]==MAX`, where MAX = 2^CNT_W − 1.
- **Issue:** `o_issue = i_valid && !hazard`. This is combinational from inputs and registered counters only.
- **Issue update:** when `o_issue && i_rd_write && i_rd!=0`, `cnt[i_rd]` increments.
- **Writeback update:** when `i_wb_valid && i_wb_rd!=0`:
  - if `cnt[i_wb_rd]!=0`, the counter decrements;
  - otherwise the counter stays 0 and `o_underflow` is set.
- **Same register, same cycle:** an issue and a writeback to one register leave its counter unchanged.
- **No same-cycle bypass:** a writeback in the same cycle does not clear a RAW hazard. The register file write lands at the clock edge, so the dependent instruction issues on the following cycle.
- **Stall counting:** `o_stall_count` increments on every cycle in which `o_stall` is 1.
- **Reset:** all counters go to 0, `o_underflow` to 0 and `o_stall_count` to 0. `o_issue` follows `i_valid` immediately after reset because no hazards exist. Reset asserted mid-stall drops all pending state at that edge.

## Timing
- Issue decision has zero latency (combinational). Counter updates take effect one cycle later.
- Writeback-to-dependent-issue: a writeback at edge N allows issue in the cycle following edge N, i.e. a minimum 1-cycle gap after the writeback cycle.
- Back-to-back independent instructions issue every cycle.
- **Handshake:**
  - decode holds `i_rs1`, `i_rs2`, `i_rd` and the used/write flags stable while `o_stall` is 1;
  - deasserting `i_valid` while stalled is legal and produces no issue and no stall count.
- `o_underflow` clears only on reset.

## Structure
- **Shared package `risky_pkg`:**
  - `REG_IDX_W = 5`;
  - `NUM_REGS = 32`;
  - `REG_ZERO = 5'd0`;
  - typedef `reg_idx_t` (logic [4:0]).
- **Sub-module `scoreboard_counter`:** one instance per register 1..31. Ports are increment and decrement inputs; outputs are `busy` (count != 0), `full` (count == MAX) and `underflow`. It owns the saturating up/down logic.
- The top level contains the index decoders, the hazard OR-reduction, the stall counter and the sticky flag.

## Test plan
- **Basic RAW stall:** reset, then issue `rd=5`, `i_rd_write=1`. Next cycle, present `rs1=5`, `rs1_used=1`.
  - Required: `o_stall=1` every cycle until `i_wb_valid`, `i_wb_rd=5`.
  - Required: `o_issue=1` on the cycle after the writeback; `o_stall_count` equals the number of stalled cycles.
- **x0 and unused operands:**
  - issue `rd=0` with write, then `rs1=0` used → issues immediately;
  - `rs2=5` pending with `rs2_used=0` → issues.
- **Capacity:** with CNT_W=2, issue three writes to `rd=7`; a fourth write to `rd=7` stalls. One writeback to 7 → the fourth issues the next cycle and `cnt[7]` ends at 3.
- **Simultaneous issue and writeback:** `cnt[3]=1`; issue a write to `rd=3` in the same cycle as a writeback to 3 → `cnt[3]` stays 1. A reader of `rs2=3` on the next cycle stalls.
- **Underflow:** after reset, `i_wb_valid=1`, `i_wb_rd=9` → `o_underflow=1` and stays 1; `cnt[9]=0`. Reset clears the flag.
- **Reset mid-stall:** a pending `rd=12` with a stalled reader, then assert `i_rst` for one cycle → after reset the reader issues immediately and `o_stall_count=0`.
